// File: rtl/planificador_pkg.sv
// Shared types and constants for the order scheduler in front of the
// coffee-machine controller.
package planificador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int RR_PTR_RST = 0;

endpackage

// File: rtl/planificador_pedidos_arbitro_rr.sv
// Combinational round-robin arbiter: first eligible requester at or after
// the pointer, searching upwards modulo N_REQ.
module arbitro_rr #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             any
);

  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/planificador_pedidos.sv
// Order scheduler: round-robin grant of front-panel requests into a FIFO,
// one-at-a-time issue to the controller, with a per-run watchdog.
module planificador_pedidos
  import planificador_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] req_ack,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  input  logic             cmd_ready,
  input  logic             done,
  output logic             active,
  output logic [CNT_W-1:0] queue_count,
  output logic             timeout_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  state_t state_reg, state_next;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]  cmd_id_reg;
  logic [N_REQ-1:0] flags_reg, req_ack_reg;
  logic [WD_W-1:0]  wdog_reg;
  logic             timeout_err_reg;

  logic [N_REQ-1:0] active_mask, issue_mask, eligible, grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any, push, pop;
  logic             active_int, cmd_valid_int, load_wdog, wdog_dec, fire_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_masks
      assign active_mask[gi] = active_int && (cmd_id_reg == ID_W'(gi));
      assign issue_mask[gi]  = (state_reg == ISSUE) && (cmd_id_reg == ID_W'(gi));
    end
  endgenerate

  assign eligible = req & ~flags_reg & ~active_mask;

  arbitro_rr #(.N_REQ(N_REQ)) u_arbitro (
    .eligible (eligible),
    .ptr      (rr_ptr_reg),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  // Grant decision uses the count before any same-cycle pop.
  assign push        = grant_any && (count_reg < CNT_W'(DEPTH));
  assign rr_ptr_next = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = ISSUE;
      ISSUE:   if (cmd_ready) state_next = RUN;
      RUN:     if (done || wdog_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    active_int    = 1'b0;
    cmd_valid_int = 1'b0;
    pop           = 1'b0;
    load_wdog     = 1'b0;
    wdog_dec      = 1'b0;
    fire_timeout  = 1'b0;
    case (state_reg)
      IDLE:  pop = (count_reg != '0);
      ISSUE: begin
        active_int    = 1'b1;
        cmd_valid_int = 1'b1;
        load_wdog     = cmd_ready;
      end
      RUN: begin
        active_int = 1'b1;
        if (!done) begin
          if (wdog_reg == '0) fire_timeout = 1'b1;
          else                wdog_dec     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= grant_id;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rr_ptr_reg      <= ID_W'(RR_PTR_RST);
      cmd_id_reg      <= '0;
      flags_reg       <= '0;
      req_ack_reg     <= '0;
      wdog_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      req_ack_reg <= push ? grant : '0;
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        rr_ptr_reg <= rr_ptr_next;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        cmd_id_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // Popped ID's flag is dropped once it sits in cmd_id; it stays
      // ineligible meanwhile because it is the active ID.
      flags_reg <= (flags_reg | (push ? grant : '0)) & ~issue_mask;
      if (load_wdog)     wdog_reg <= WD_W'(TIMEOUT - 1);
      else if (wdog_dec) wdog_reg <= wdog_reg - WD_W'(1);
      if (fire_timeout) timeout_err_reg <= 1'b1;
    end
  end

  assign req_ack     = req_ack_reg;
  assign cmd_valid   = cmd_valid_int;
  assign cmd_id      = cmd_id_reg;
  assign active      = active_int;
  assign queue_count = count_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_planificador_pedidos.sv
// Directed bench for planificador_pedidos: instance A (DEPTH=4, TIMEOUT=8)
// and instance B (DEPTH=2) for the full-queue case.
module tb_planificador_pedidos;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_ack_a, req_b, req_ack_b;
  logic       cmd_valid_a, cmd_ready_a, done_a, active_a, timeout_err_a;
  logic       cmd_valid_b, cmd_ready_b, done_b, active_b, timeout_err_b;
  logic [1:0] cmd_id_a, cmd_id_b;
  logic [2:0] queue_count_a;
  logic [1:0] queue_count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  planificador_pedidos #(.N_REQ(4), .DEPTH(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_ack(req_ack_a),
    .cmd_valid(cmd_valid_a), .cmd_id(cmd_id_a), .cmd_ready(cmd_ready_a),
    .done(done_a), .active(active_a), .queue_count(queue_count_a),
    .timeout_err(timeout_err_a)
  );

  planificador_pedidos #(.N_REQ(4), .DEPTH(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_ack(req_ack_b),
    .cmd_valid(cmd_valid_b), .cmd_id(cmd_id_b), .cmd_ready(cmd_ready_b),
    .done(done_b), .active(active_b), .queue_count(queue_count_b),
    .timeout_err(timeout_err_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_a = '0; cmd_ready_a = 1'b0; done_a = 1'b0;
    req_b = '0; cmd_ready_b = 1'b0; done_b = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  bit         hs;
  logic [1:0] hs_id;
  int         n_hs, dly, n_ack;
  logic [3:0] exp_ack_b [8];

  initial begin
    // Reset state
    do_reset();
    check_val("rst_req_ack", req_ack_a, 4'b0000);
    check_val("rst_cmd_valid", cmd_valid_a, 1'b0);
    check_val("rst_cmd_id", cmd_id_a, 2'd0);
    check_val("rst_active", active_a, 1'b0);
    check_val("rst_count", queue_count_a, 3'd0);
    check_val("rst_timeout_err", timeout_err_a, 1'b0);

    // Single order
    req_a = 4'b0100;
    tick();
    check_val("single_ack", req_ack_a, 4'b0100);
    check_val("single_count1", queue_count_a, 3'd1);
    check_val("single_valid_early", cmd_valid_a, 1'b0);
    tick();
    check_val("single_ack_pulse", req_ack_a, 4'b0000);
    check_val("single_valid", cmd_valid_a, 1'b1);
    check_val("single_id", cmd_id_a, 2'd2);
    check_val("single_count0", queue_count_a, 3'd0);
    cmd_ready_a = 1'b1;
    tick();
    check_val("single_run_valid", cmd_valid_a, 1'b0);
    check_val("single_run_active", active_a, 1'b1);
    req_a = '0; cmd_ready_a = 1'b0; done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check_val("single_done_active", active_a, 1'b0);

    // Simultaneous push/pop and FIFO order
    do_reset();
    req_a = 4'b0111;
    tick();
    check_val("pp_ack0", req_ack_a, 4'b0001);
    check_val("pp_count_a", queue_count_a, 3'd1);
    tick();
    check_val("pp_ack1", req_ack_a, 4'b0010);
    check_val("pp_count_same", queue_count_a, 3'd1);
    check_val("pp_id0", cmd_id_a, 2'd0);
    tick();
    check_val("pp_ack2", req_ack_a, 4'b0100);
    check_val("pp_count2", queue_count_a, 3'd2);
    req_a = '0; cmd_ready_a = 1'b1;
    tick();
    cmd_ready_a = 1'b0; done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    check_val("pp_id1", cmd_id_a, 2'd1);
    check_val("pp_count_after1", queue_count_a, 3'd1);
    cmd_ready_a = 1'b1;
    tick();
    cmd_ready_a = 1'b0; done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    check_val("pp_id2", cmd_id_a, 2'd2);
    check_val("pp_count_after2", queue_count_a, 3'd0);

    // Fairness: controller acks everything, done three cycles after handshake
    do_reset();
    req_a = 4'b1111; cmd_ready_a = 1'b1;
    n_hs = 0; dly = 0;
    for (int cyc = 0; cyc < 80 && n_hs < 8; cyc++) begin
      hs    = cmd_valid_a && cmd_ready_a;
      hs_id = cmd_id_a;
      tick();
      if (cyc < 4) check_val($sformatf("fair_ack_c%0d", cyc), req_ack_a, 32'd1 << cyc);
      if (done_a) done_a = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) done_a = 1'b1;
      end
      if (hs) begin
        check_val($sformatf("fair_issue%0d", n_hs), hs_id, n_hs % 4);
        n_hs++;
        dly = 2;
      end
    end
    check_val("fair_handshakes", n_hs, 8);

    // done on the cycle the watchdog reaches zero is a normal completion
    do_reset();
    req_a = 4'b0001;
    tick();
    req_a = '0;
    tick();
    cmd_ready_a = 1'b1;
    tick();
    cmd_ready_a = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_val("edge_active_before", active_a, 1'b1);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check_val("edge_no_err", timeout_err_a, 1'b0);
    check_val("edge_idle", active_a, 1'b0);

    // Watchdog expiry
    do_reset();
    req_a = 4'b0011;
    tick();
    tick();
    req_a = '0; cmd_ready_a = 1'b1;
    tick();
    cmd_ready_a = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_val("wd_err_early", timeout_err_a, 1'b0);
    check_val("wd_active_early", active_a, 1'b1);
    tick();
    check_val("wd_err_set", timeout_err_a, 1'b1);
    check_val("wd_idle", active_a, 1'b0);
    tick();
    check_val("wd_next_valid", cmd_valid_a, 1'b1);
    check_val("wd_next_id", cmd_id_a, 2'd1);
    check_val("wd_err_sticky", timeout_err_a, 1'b1);

    // Reset in the middle of a run with entries queued
    cmd_ready_a = 1'b1; req_a = 4'b1001;
    tick();
    check_val("mid_ack3", req_ack_a, 4'b1000);
    cmd_ready_a = 1'b0;
    tick();
    check_val("mid_count", queue_count_a, 3'd2);
    rst = 1'b0;
    tick();
    check_val("mid_req_ack", req_ack_a, 4'b0000);
    check_val("mid_cmd_valid", cmd_valid_a, 1'b0);
    check_val("mid_cmd_id", cmd_id_a, 2'd0);
    check_val("mid_active", active_a, 1'b0);
    check_val("mid_count0", queue_count_a, 3'd0);
    check_val("mid_err_clear", timeout_err_a, 1'b0);
    rst = 1'b1; req_a = '0; done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check_val("post_active", active_a, 1'b0);
    check_val("post_count", queue_count_a, 3'd0);
    check_val("post_err", timeout_err_a, 1'b0);

    // Full queue on the DEPTH=2 instance
    do_reset();
    exp_ack_b = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    req_b = 4'b1111;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val($sformatf("full_ack_c%0d", i), req_ack_b, exp_ack_b[i]);
      n_ack += $countones(req_ack_b);
    end
    check_val("full_ack_total", n_ack, 3);
    check_val("full_count", queue_count_b, 2'd2);
    check_val("full_head", cmd_id_b, 2'd0);
    cmd_ready_b = 1'b1;
    tick();
    cmd_ready_b = 1'b0; done_b = 1'b1;
    tick();
    done_b = 1'b0;
    check_val("full_done_ack", req_ack_b, 4'b0000);
    check_val("full_done_idle", active_b, 1'b0);
    tick();
    check_val("full_pop_ack", req_ack_b, 4'b0000);
    check_val("full_pop_count", queue_count_b, 2'd1);
    check_val("full_pop_id", cmd_id_b, 2'd1);
    tick();
    check_val("full_regrant", req_ack_b, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/planificador_pedidos.md
# planificador_pedidos

Order scheduler in front of the microprogrammed coffee-machine controller. It collects drink requests from `N_REQ` front-panel requesters and grants them fairly with a round-robin arbiter. Grants are queued in a small FIFO and issued one at a time to the controller over a valid/ready start handshake. A watchdog guards each run against a controller that never reports completion.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters; ≥2.
- `ID_W`, `$clog2(N_REQ)` — width of a requester ID.
- `DEPTH`, 4 — FIFO entries; 1..`N_REQ`.
- `TIMEOUT`, 1024 — maximum cycles a run may last; ≥2.
- `CNT_W`, `$clog2(DEPTH+1)` — width of the queue count.

Ports:
- `clk` in 1 — the single clock; all logic on the rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `req` in `N_REQ` — level request per requester.
- `req_ack` out `N_REQ` — one-hot, one-cycle pulse when a request is queued.
- `cmd_valid` out 1 — start command to the controller is valid.
- `cmd_id` out `ID_W` — drink/requester ID for that command.
- `cmd_ready` in 1 — controller accepts the start.
- `done` in 1 — controller finished the current run; single-cycle pulse.
- `active` out 1 — a command is issued or running.
- `queue_count` out `CNT_W` — occupied FIFO entries.
- `timeout_err` out 1 — sticky watchdog error.

## Operation
- **Reset** (`rst`=0 at an edge): state IDLE; FIFO empty; `queue_count`=0; round-robin pointer 0; all in-queue flags 0; watchdog 0. Outputs after reset: `req_ack`=0, `cmd_valid`=0, `cmd_id`=0, `active`=0, `timeout_err`=0. Reset mid-run aborts the run silently; no `done` is expected afterwards.
- **Eligibility.** Requester i is eligible when `req[i]`=1, its in-queue flag is 0, and it is not the active ID. At most one entry per requester exists at any time.
- **Arbitration.** At most one grant per cycle, and only when `queue_count` < `DEPTH` (count before any same-cycle pop). The search starts at the pointer and increases modulo `N_REQ`. The winner is pushed, its flag is set, and its `req_ack` bit pulses. The pointer becomes winner+1 mod `N_REQ`. With no grant, the pointer holds.
- **FIFO.** Push and pop in the same cycle are allowed; `queue_count` is then unchanged. Read and write pointers wrap at `DEPTH`. The FIFO is never read when empty and never written when full.
- **FSM:**
  - IDLE: if `queue_count`>0, pop the head into `cmd_id`, clear that ID's in-queue flag, go to ISSUE. Otherwise stay.
  - ISSUE: `cmd_valid`=1 and `cmd_id` is held stable. On `cmd_valid && cmd_ready`, load the watchdog with `TIMEOUT-1` and go to RUN.
  - RUN: on `done`=1, go to IDLE. Otherwise, if the watchdog is 0, set `timeout_err` and go to IDLE (run abandoned). Otherwise decrement the watchdog.
- `active`=1 in ISSUE and RUN.
- `done` in IDLE or ISSUE is ignored.
- `done` on the same cycle the watchdog reaches 0 counts as a normal completion.
- `timeout_err` clears only on reset. Scheduling continues after an error.

## Timing
- `req[i]` rises before edge k. At edge k: grant, and `req_ack[i]`=1 during cycle k→k+1; `queue_count` increments.
- At edge k+1: pop. `cmd_valid`=1 from edge k+1, giving 2-cycle request-to-command latency when idle.
- `cmd_ready` is sampled at the edge; the handshake completes at edge k+2 at the earliest, and `cmd_valid` drops after that edge.
- From IDLE with a non-empty queue, the next command is presented 1 cycle after the pop decision. Minimum spacing between consecutive handshakes: 3 cycles (RUN→IDLE→ISSUE).
- Timeout fires at the edge `TIMEOUT` cycles after the handshake edge if no `done` was sampled at any of those edges.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `planificador_pkg`:
  - state enum {IDLE, ISSUE, RUN};
  - a localparam for the reset value of the round-robin pointer.
- Sub-module `arbitro_rr` (parameter `N_REQ`), which is purely combinational:
  - inputs: eligible vector, pointer;
  - outputs: one-hot grant, grant ID, `any`.
- The pointer register, FIFO array, flags, FSM, and watchdog live in the top level.

## Test plan
- **Single order.** After reset, `req`=4'b0100 held. Expect `req_ack`=4'b0100 one cycle; `cmd_valid`=1 with `cmd_id`=2 two cycles after the request. With `cmd_ready`=1 the state goes to RUN; `done` pulse → `active`=0.
- **Fairness.** `req`=4'b1111 held, controller acks every command and returns `done` 3 cycles later. Expect grants 0,1,2,3 on consecutive cycles. Expect issued IDs 0,1,2,3,0,1… with no ID served twice before all others.
- **Full queue.** `DEPTH`=2, `cmd_ready`=0, `req`=4'b1111. Expect exactly 3 acks (1 active + 2 queued), after which `queue_count`=2 stays. No further `req_ack` until a pop.
- **Simultaneous push/pop.** `queue_count`=1 in IDLE while a new requester is granted. Expect `queue_count` to stay 1 and the FIFO order preserved.
- **Watchdog.** `TIMEOUT`=8, handshake then no `done`. Expect `timeout_err`=1 exactly 8 edges after the handshake, state IDLE, and the next queued ID issued.
- **Boundary `done` and reset.** `done` on the cycle the watchdog hits 0 → no error. Then `rst`=0 during RUN → all outputs 0 next cycle and queue empty.
